// File: rtl/rom_rr_arbiter.sv
// Round-robin arbiter that shares one combinational lookup ROM between two
// requesters. One lookup is in flight at a time: accept, ROM read, response.
module rom_rr_arbiter #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              rsp0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    input  logic              rsp1_ready,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [CNT_W-1:0]  lookup_cnt
);

    typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_grant;
    logic              grant_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              win0;
    logic              win1;
    logic              rsp_done;

    // ROM address is held in a register so it stays stable in every state.
    assign rom_addr = addr_q;

    // Round-robin winner: a lone requester wins; on a tie the one that was
    // not served last wins.
    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        if (req0_valid && (!req1_valid || last_grant)) begin
            win0 = 1'b1;
        end else if (req1_valid) begin
            win1 = 1'b1;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp0_data  = '0;
        rsp1_data  = '0;
        rsp_done   = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = win0;
                req1_ready = win1;
                if (win0 || win1) begin
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (grant_q) begin
                    rsp1_valid = 1'b1;
                    rsp1_data  = data_q;
                    rsp_done   = rsp1_ready;
                end else begin
                    rsp0_valid = 1'b1;
                    rsp0_data  = data_q;
                    rsp_done   = rsp0_ready;
                end
                if (rsp_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset drops any in-flight lookup.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Captured request, ROM data, priority pointer and completion counter.
    // Priority only moves when a response drains, so a stalled requester
    // keeps its turn until it is served.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            grant_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            lookup_cnt <= '0;
        end else begin
            if (state == IDLE && (win0 || win1)) begin
                addr_q  <= win0 ? req0_addr : req1_addr;
                grant_q <= win1;
            end
            if (state == LOOKUP) begin
                data_q <= rom_data;
            end
            if (rsp_done) begin
                last_grant <= grant_q;
                lookup_cnt <= lookup_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// Bench for rom_rr_arbiter: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model of the arbitration rules.
module tb_rom_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       r0v, r1v, s0r, s1r;
    logic [2:0] r0a, r1a;
    logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [1:0] rsp0_data, rsp1_data;
    logic [2:0] rom_addr;
    logic [1:0] rom_data;
    logic [7:0] lookup_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // model of the outstanding transaction and arbitration history
    bit busy;
    int acc_cyc, cur_req, cur_data, last, cnt, last_addr, cyc;
    bit acc0, acc1, done;
    int order[$];

    always #5 clk = ~clk;

    // Bench ROM: data = address mod 4
    assign rom_data = rom_addr[1:0];

    rom_rr_arbiter #(.ADDR_W(3), .DATA_W(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req0_addr(r0a), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(s0r),
        .req1_valid(r1v), .req1_addr(r1a), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(s1r),
        .rom_addr(rom_addr), .rom_data(rom_data), .lookup_cnt(lookup_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        busy = 0; last = 1; cnt = 0; last_addr = 0; acc_cyc = 0; cur_req = 0; cur_data = 0;
    endtask

    // One clock cycle: check outputs against the model at the falling edge,
    // then advance the model with the handshakes that the rules imply.
    task automatic step();
        bit e0, e1, rsp_on, ev0, ev1;
        @(negedge clk);
        e0 = 0; e1 = 0;
        if (!busy) begin
            if (r0v && (!r1v || last == 1)) e0 = 1;
            else if (r1v) e1 = 1;
        end
        rsp_on = busy && (cyc >= acc_cyc + 2);
        ev0 = rsp_on && cur_req == 0;
        ev1 = rsp_on && cur_req == 1;
        chk("req0_ready", 32'(req0_ready), 32'(e0));
        chk("req1_ready", 32'(req1_ready), 32'(e1));
        chk("rsp0_valid", 32'(rsp0_valid), 32'(ev0));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(ev1));
        chk("rsp0_data", 32'(rsp0_data), ev0 ? cur_data : 0);
        chk("rsp1_data", 32'(rsp1_data), ev1 ? cur_data : 0);
        chk("rom_addr", 32'(rom_addr), last_addr);
        chk("lookup_cnt", 32'(lookup_cnt), cnt);
        acc0 = 0; acc1 = 0; done = 0;
        if (rst) begin
            model_reset();
        end else begin
            if (rsp_on && ((ev0 && s0r) || (ev1 && s1r))) begin
                busy = 0; last = cur_req; cnt = (cnt + 1) % 256; done = 1;
            end
            if (e0) begin
                busy = 1; acc_cyc = cyc; cur_req = 0; cur_data = int'(r0a) % 4;
                last_addr = int'(r0a); acc0 = 1; order.push_back(0);
            end else if (e1) begin
                busy = 1; acc_cyc = cyc; cur_req = 1; cur_data = int'(r1a) % 4;
                last_addr = int'(r1a); acc1 = 1; order.push_back(1);
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; step(); step(); rst = 0;
    endtask

    initial begin
        int n_done;
        bit got;
        rst = 1; r0v = 0; r1v = 0; s0r = 0; s1r = 0; r0a = 0; r1a = 0;
        cyc = 0; model_reset();
        #1;
        do_reset();
        step();
        chk("reset_cnt", 32'(lookup_cnt), 0);

        // single request from requester 0, address 6
        r0v = 1; r0a = 3'd6; s0r = 0;
        step();
        chk("single_accept", 32'(acc0), 1);
        r0v = 0;
        step();
        chk("single_rsp_data", 32'(rsp0_data), 2);
        chk("single_rsp_valid", 32'(rsp0_valid), 1);
        s0r = 1; step(); s0r = 0;
        chk("single_cnt", 32'(lookup_cnt), 1);
        step();

        // simultaneous requests alternate strictly
        do_reset();
        order.delete();
        r0v = 1; r0a = 3'd5; r1v = 1; r1a = 3'd7; s0r = 1; s1r = 1;
        for (int i = 0; i < 60; i++) step();
        chk("alt_count", order.size(), 20);
        for (int i = 0; i < order.size(); i++) chk("alt_order", order[i], i % 2);
        r0v = 0; r1v = 0;
        for (int i = 0; i < 3; i++) step();

        // response backpressure on requester 1 while requester 0 waits
        do_reset();
        r1v = 1; r1a = 3'd3; s1r = 0;
        step();
        chk("bp_acc1", 32'(acc1), 1);
        r1v = 0; r0v = 1; r0a = 3'd2;
        for (int i = 0; i < 6; i++) step();
        chk("bp_stall_valid", 32'(rsp1_valid), 1);
        chk("bp_stall_data", 32'(rsp1_data), 3);
        chk("bp_stall_ready0", 32'(req0_ready), 0);
        s1r = 1; step(); s1r = 0;
        step();
        chk("bp_acc0_after", 32'(acc0), 1);
        r0v = 0; s0r = 1;
        for (int i = 0; i < 3; i++) step();
        s0r = 0;

        // reset during LOOKUP, then during RESP
        r0v = 1; r0a = 3'd1; step(); r0v = 0;
        rst = 1; step(); rst = 0;
        step();
        chk("rst_lookup_cnt", 32'(lookup_cnt), 0);
        chk("rst_lookup_rsp", 32'(rsp0_valid), 0);
        r1v = 1; r1a = 3'd4; step(); r1v = 0; step();
        s1r = 1; rst = 1; step(); rst = 0; s1r = 0;
        step();
        chk("rst_resp_rsp1", 32'(rsp1_valid), 0);
        chk("rst_resp_cnt", 32'(lookup_cnt), 0);
        r0v = 1; r0a = 3'd7; s0r = 1; step(); r0v = 0; step(); step(); step();
        chk("post_rst_cnt", 32'(lookup_cnt), 1);

        // counter wraps after 256 completions
        do_reset();
        r0v = 1; s0r = 1; n_done = 0; got = 0;
        for (int i = 0; i < 900 && n_done < 257; i++) begin
            r0a = 3'($urandom_range(0, 7));
            if (!busy) begin step(); end else step();
            if (done) begin
                n_done++;
                if (n_done == 256) chk("wrap_zero", 32'(lookup_cnt), 0);
                if (n_done == 257) begin chk("wrap_one", 32'(lookup_cnt), 1); got = 1; end
            end
        end
        chk("wrap_reached", 32'(got), 1);
        r0v = 0;
        for (int i = 0; i < 3; i++) step();

        // response ready with nothing pending changes nothing
        s0r = 1; s1r = 1;
        for (int i = 0; i < 5; i++) step();
        chk("idle_ready_cnt", 32'(lookup_cnt), 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if (!r0v && $urandom_range(0, 2) == 0) begin r0v = 1; r0a = 3'($urandom_range(0, 7)); end
            if (!r1v && $urandom_range(0, 2) == 0) begin r1v = 1; r1a = 3'($urandom_range(0, 7)); end
            s0r = 1'($urandom_range(0, 1));
            s1r = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 199) == 0);
            step();
            if (acc0) r0v = 0;
            if (acc1) r1v = 0;
        end
        rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
